seq_shift_sub_divider: RTL and testbench
========================================

Name: seq_shift_sub_divider

Overview:
- Sequential restoring (shift-subtract) divider. It is the inverse companion of the team's shift-add multiplier datapath (accumulator / multiplier / multiplicand registers sequenced by a CT counter).
- Divides a 2W-bit dividend by a W-bit divisor, producing one quotient bit per clock.
- Uses a start/busy/done handshake and sits beside the multiplier in the arithmetic cluster.
- Results are held stable until the next accepted start.

Parameters:
- WIDTH, 4, divisor and remainder width W. Dividend and quotient are 2W bits. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE
- dividend  input  2*WIDTH  sampled on the accepting edge only
- divisor  input  WIDTH  sampled on the accepting edge only
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, high while in DONE
- quotient  output  2*WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  flag for the last operation, held like results

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset overrides everything, including mid-CALC; the partial result is discarded.
- States: IDLE, CALC, DONE. Outputs decode directly from state and registers; no combinational input-to-output path.
- IDLE, start=1, divisor!=0 at edge t0:
  - Load: quotient register <- dividend; partial remainder R (W+1 bits) <- 0; divisor register <- divisor; counter <- 2W-1; div_by_zero <- 0.
  - Next state CALC.
- IDLE, start=1, divisor==0 at edge t0:
  - quotient <- all ones; remainder <- dividend[W-1:0]; div_by_zero <- 1.
  - Next state DONE. done is high in the cycle after t0.
- IDLE, start=0: hold all registers.
- CALC iteration, one per edge:
  - Shift {R, Q} left by 1; the MSB of Q enters the LSB of R.
  - T = R_shifted - {0, divisor}, computed at W+1 bits.
  - If T is non-negative (borrow=0): R <- T, Q LSB <- 1. Otherwise keep R_shifted, Q LSB <- 0.
  - Counter decrements. On the iteration with counter==0, next state is DONE.
  - Exactly 2W iterations, at edges t0+1 .. t0+2W.
- Invariant: R < divisor after every iteration, so the remainder output is R[W-1:0]. The MSB of R is zero at completion.
- DONE: done=1 for exactly one cycle (the cycle after edge t0+2W). Next state is always IDLE.
- Latency: done is high 2W+1 cycles after the start cycle (9 cycles for W=4). Throughput is one operation per 2W+2 cycles.
- start in CALC or DONE is ignored, and dividend/divisor changes are ignored. start in the same cycle done is high is not accepted; it must be re-presented in IDLE.
- quotient, remainder and div_by_zero outputs change only at:
  - the DONE transition (registered copy), or
  - the divide-by-zero load.
  - They stay stable during CALC, showing the previous result.
- Unsigned arithmetic throughout. Dividend < divisor gives quotient=0 and remainder=dividend.

Decomposition:
- Shared package arith_pkg:
  - state enum (IDLE, CALC, DONE)
  - function for counter width, clog2(2*WIDTH)
  - localparam defaults
- One natural sub-module: div_step, a combinational single iteration. Inputs R, Q MSB, divisor; outputs next R and quotient bit. It can be reused for an unrolled variant.

Test Plan:
- W=4, dividend=143, divisor=11, start 1 cycle -> busy high 9 cycles; done pulse on cycle 9; quotient=13, remainder=0, div_by_zero=0.
- dividend=100, divisor=7 -> quotient=14, remainder=2. Then dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=15 -> quotient=0, remainder=5.
- divisor=0, dividend=0xA7 -> done in the cycle after start; quotient=0xFF, remainder=0x7, div_by_zero=1. A following 143/11 clears div_by_zero to 0.
- Start 143/11, then raise start with 200/3 on CALC cycle 4 and on the done cycle -> both ignored; result is 13 r 0. A new start in IDLE gives 66 r 2.
- Start 200/3, assert rst_n=0 on CALC cycle 5 -> next cycle busy=0, done=0, all outputs 0. A fresh 200/3 gives quotient=66, remainder=2.
- Random unsigned sweep, all 2^12 dividend/divisor pairs for W=4 -> matches the reference model (q = a/b, r = a%b). done is exactly one cycle wide every time.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic cluster (multiplier, divider).
// Holds the sequencer state encoding and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // Iteration counter must hold 2W-1
    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/seq_shift_sub_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
// Purely combinational so it can be chained for an unrolled divider.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   r_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] diff;

    assign sh      = {r_i, q_msb_i};
    assign diff    = sh - {2'b00, divisor_i};
    assign q_bit_o = (sh >= {2'b00, divisor_i});
    // R stays below the divisor, so the top bit of sh/diff is always zero
    assign r_o     = (WIDTH+1)'(q_bit_o ? diff : sh);

endmodule

// File: rtl/seq_shift_sub_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module seq_shift_sub_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int QW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

    div_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [QW-1:0]  q_q;
    logic [WIDTH:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic           busy_q;
    logic           done_q;
    logic [QW-1:0]  quo_q;
    logic [WIDTH-1:0] rem_q;
    logic           dbz_q;

    logic [WIDTH:0] r_d;
    logic           q_bit;
    logic [QW-1:0]  q_d;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i      (r_q),
        .q_msb_i  (q_q[QW-1]),
        .divisor_i(d_q),
        .r_o      (r_d),
        .q_bit_o  (q_bit)
    );

    assign q_d = {q_q[QW-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to DONE
                            quo_q   <= '1;
                            rem_q   <= dividend[WIDTH-1:0];
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            q_q     <= dividend;
                            r_q     <= '0;
                            d_q     <= divisor;
                            cnt_q   <= CNT_LAST;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_q   <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_shift_sub_divider.sv
// Scoreboard bench for seq_shift_sub_divider (W=4): directed cases plus
// an exhaustive sweep in shuffled order against a plain-arithmetic model.
module tb_seq_shift_sub_divider;

    localparam int W  = 4;
    localparam int QW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [QW-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    seq_shift_sub_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: compare on every done, otherwise results must hold
    int hq = 0;
    int hr = 0;
    int hz = 0;
    int prev_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hq = 0;
            hr = 0;
            hz = 0;
            prev_done = 0;
        end else begin
            if (done) begin
                check("done_width", prev_done, 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                    hq = int'(quotient);
                    hr = int'(remainder);
                    hz = int'(div_by_zero);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(quotient), e.q);
                    check("remainder", int'(remainder), e.r);
                    check("div_by_zero", int'(div_by_zero), e.z);
                    hq = e.q;
                    hr = e.r;
                    hz = e.z;
                end
            end else begin
                check("hold_quotient", int'(quotient), hq);
                check("hold_remainder", int'(remainder), hr);
                check("hold_dbz", int'(div_by_zero), hz);
            end
            prev_done = int'(done);
        end
    end

    task automatic issue(input int a, input int b);
        exp_t x;
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        if (b == 0) begin
            x.q = (1 << QW) - 1;
            x.r = a % (1 << W);
            x.z = 1;
        end else begin
            x.q = a / b;
            x.r = a % b;
            x.z = 0;
        end
        sb.push_back(x);
        start    = 1'b1;
        dividend = QW'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = QW'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(input int exp_n, input string nm);
        int n = 0;
        while (!done && n < 40) begin
            check({nm, "_busy"}, int'(busy), 1);
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, n, exp_n);
    endtask

    int order[4096];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(143, 11); wait_done(2 * W, "d143_11");
        issue(100, 7);  wait_done(2 * W, "d100_7");
        issue(255, 1);  wait_done(2 * W, "d255_1");
        issue(5, 15);   wait_done(2 * W, "d5_15");
        issue(8'hA7, 0); wait_done(0, "dzero");
        issue(143, 11); wait_done(2 * W, "d143_11b");

        // Starts during CALC and on the done cycle must be ignored
        issue(143, 11);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2 * W - 5, "ign_calc");
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_done_busy", int'(busy), 0);
        issue(200, 3); wait_done(2 * W, "d200_3");

        // Reset mid-CALC discards the operation
        issue(200, 3);
        void'(sb.pop_back());
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_quotient", int'(quotient), 0);
        check("mid_rst_remainder", int'(remainder), 0);
        check("mid_rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(200, 3); wait_done(2 * W, "post_rst");

        // Exhaustive sweep, shuffled, with random idle gaps
        for (int i = 0; i < 4096; i++) order[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 4096; i++) begin
            int a;
            int b;
            a = order[i] >> W;
            b = order[i] % (1 << W);
            issue(a, b);
            wait_done((b == 0) ? 0 : 2 * W, "sweep");
            repeat ($urandom_range(1, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
